// File: rtl/apb_protocol_monitor.sv
// rtl/apb_protocol_monitor.sv - passive APB slave-port monitor: sticky violation flags, transfer stats, last-transfer capture
// Define APB_MON_TIMEOUT_EN to build the wait-state counter and the err_flags[5] TIMEOUT check.
module apb_protocol_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  input  logic [ADDR_WIDTH-1:0]  PADDR,
  input  logic [DATA_WIDTH-1:0]  PWDATA,
  input  logic [DATA_WIDTH-1:0]  PRDATA,
  input  logic                   clr,
  output logic [5:0]             err_flags,
  output logic                   err_pulse,
  output logic                   xfer_done,
  output logic [ADDR_WIDTH-1:0]  last_addr,
  output logic [DATA_WIDTH-1:0]  last_data,
  output logic                   last_write,
  output logic [COUNT_WIDTH-1:0] wr_count,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic [COUNT_WIDTH-1:0] slverr_count
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_write;
  logic                  capture, access, done;
  logic [4:0]            viol;
  logic                  timeout_hit;
  logic [5:0]            viol_all;

  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] cnt,
                                                  input logic inc, input logic zero);
    logic [COUNT_WIDTH-1:0] base;
    base = zero ? '0 : cnt;
    return (inc && base != '1) ? base + COUNT_WIDTH'(1) : base;
  endfunction

  // The SETUP->ACCESS edge is itself the first ACCESS cycle, so a zero-wait
  // transfer completes there and takes only two edges.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    access  = 1'b0;
    viol    = '0;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_n = SETUP;
          capture = 1'b1;
        end else if (PENABLE) begin
          if (PSEL && xfer_done) viol[3] = 1'b1;
          else                   viol[1] = 1'b1;
        end
      end
      SETUP: begin
        if (PSEL && PENABLE) begin
          access = 1'b1;
        end else if (PSEL) begin
          viol[0] = 1'b1;
          capture = 1'b1;
        end else begin
          viol[0] = 1'b1;
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          viol[4] = 1'b1;
          state_n = IDLE;
        end else if (!PENABLE) begin
          viol[4] = 1'b1;
          capture = 1'b1;
          state_n = SETUP;
        end else begin
          access = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (access) begin
      if (PADDR != cap_addr || PWRITE != cap_write || (cap_write && PWDATA != cap_wdata))
        viol[2] = 1'b1;
      state_n = PREADY ? IDLE : ACCESS;
    end
  end

  assign done     = access && PREADY;
  assign viol_all = {timeout_hit, viol};

`ifdef APB_MON_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt, wait_base, wait_n;

  // Counter parks at WAIT_MAX so the flag fires only once per transfer.
  always_comb begin
    wait_base   = (state == SETUP) ? '0 : wait_cnt;
    wait_n      = wait_cnt;
    timeout_hit = 1'b0;
    if (access) begin
      wait_n = wait_base;
      if (!PREADY && wait_base != WAIT_MAX) begin
        wait_n      = wait_base + WAIT_W'(1);
        timeout_hit = (wait_n == WAIT_MAX);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_cnt <= '0;
    else          wait_cnt <= wait_n;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= IDLE;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_write    <= 1'b0;
      err_flags    <= '0;
      err_pulse    <= 1'b0;
      xfer_done    <= 1'b0;
      last_addr    <= '0;
      last_data    <= '0;
      last_write   <= 1'b0;
      wr_count     <= '0;
      rd_count     <= '0;
      slverr_count <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        cap_addr  <= PADDR;
        cap_write <= PWRITE;
        cap_wdata <= PWDATA;
      end
      err_flags <= (clr ? 6'b0 : err_flags) | viol_all;
      err_pulse <= |viol_all;
      xfer_done <= done;
      if (done) begin
        last_addr  <= cap_addr;
        last_write <= cap_write;
        last_data  <= cap_write ? PWDATA : PRDATA;
      end
      wr_count     <= bump(wr_count, done && cap_write, clr);
      rd_count     <= bump(rd_count, done && !cap_write, clr);
      slverr_count <= bump(slverr_count, done && PSLVERR, clr);
    end
  end

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb/tb_apb_protocol_monitor.sv - directed and randomized bench for apb_protocol_monitor
// Honours APB_MON_TIMEOUT_EN for the TIMEOUT expectations.
module tb_apb_protocol_monitor;
  localparam int AW = 32, DW = 32, CW = 8, TO = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef APB_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0, PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0, PRDATA = '0;
  logic          clr = 1'b0;
  logic [5:0]    err_flags;
  logic          err_pulse, xfer_done, last_write;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [CW-1:0] wr_count, rd_count, slverr_count;

  apb_protocol_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .clr(clr), .err_flags(err_flags), .err_pulse(err_pulse), .xfer_done(xfer_done),
    .last_addr(last_addr), .last_data(last_data), .last_write(last_write),
    .wr_count(wr_count), .rd_count(rd_count), .slverr_count(slverr_count)
  );

  always #5 PCLK = ~PCLK;

  int         n_assert = 0, n_fail = 0;
  int         exp_wr = 0, exp_rd = 0, exp_slv = 0;
  logic [5:0] exp_flags = '0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_wr"}, 64'(wr_count), 64'(sat(exp_wr)));
    chk({tag, "_rd"}, 64'(rd_count), 64'(sat(exp_rd)));
    chk({tag, "_slv"}, 64'(slverr_count), 64'(sat(exp_slv)));
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1; step(); clr = 1'b0;
    exp_wr = 0; exp_rd = 0; exp_slv = 0; exp_flags = '0;
    chk("clr_flags", 64'(err_flags), 64'(0));
    chk_counts("clr");
  endtask

  // One clean transfer; leaves the bus idle-driven but unclocked so back-to-back works.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input int waits, input bit serr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wr ? data : 32'($urandom); PREADY = 1'b0; PSLVERR = 1'b0;
    step();
    PENABLE = 1'b1;
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = 32'($urandom);
      step();
      chk("wait_no_done", 64'(xfer_done), 64'(0));
    end
    PREADY = 1'b1; PSLVERR = serr; PRDATA = wr ? 32'($urandom) : data;
    step();
    if (wr) exp_wr++; else exp_rd++;
    if (serr) exp_slv++;
    chk("xfer_done", 64'(xfer_done), 64'(1));
    chk("last_addr", 64'(last_addr), 64'(addr));
    chk("last_data", 64'(last_data), 64'(data));
    chk("last_write", 64'(last_write), 64'(wr));
    chk("xfer_flags", 64'(err_flags), 64'(exp_flags));
    chk_counts("xfer");
    idle();
  endtask

  initial begin
    step(); step();
    chk("rst_flags", 64'(err_flags), 64'(0));
    chk("rst_pulse", 64'(err_pulse), 64'(0));
    chk("rst_done", 64'(xfer_done), 64'(0));
    chk("rst_laddr", 64'(last_addr), 64'(0));
    chk("rst_ldata", 64'(last_data), 64'(0));
    chk("rst_lwrite", 64'(last_write), 64'(0));
    chk_counts("rst");
    PRESETn = 1'b1;
    step();

    // Zero-wait write then back-to-back two-wait read.
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    xfer(1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b0);
    step();
    chk("pulse_one_cycle", 64'(xfer_done), 64'(0));
    chk("tp1_flags", 64'(err_flags), 64'(0));

    // PSEL & PENABLE together from IDLE.
    PSEL = 1'b1; PENABLE = 1'b1; step();
    chk("ens_flags", 64'(err_flags), 64'(6'b000010));
    chk("ens_pulse", 64'(err_pulse), 64'(1));
    chk_counts("ens");
    idle(); step();
    chk("ens_pulse_drop", 64'(err_pulse), 64'(0));
    chk("ens_sticky", 64'(err_flags), 64'(6'b000010));
    do_clr();

    // PENABLE held after a completion.
    xfer(1'b1, 32'h14, 32'h1234_5678, 0, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b1; step();
    chk("end_flags", 64'(err_flags), 64'(6'b001000));
    do_clr();

    // Address change during the second wait state of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'hA5A5_0001; step();
    PENABLE = 1'b1; PREADY = 1'b0; step();
    chk("unst_w1", 64'(err_flags), 64'(0));
    PADDR = 32'h24; step();
    chk("unst_flag", 64'(err_flags), 64'(6'b000100));
    chk("unst_pulse", 64'(err_pulse), 64'(1));
    PREADY = 1'b1; step();
    exp_wr++;
    chk("unst_done", 64'(xfer_done), 64'(1));
    chk_counts("unst");
    do_clr();

    // Twenty wait states.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h30; step();
    PENABLE = 1'b1; PREADY = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("to_flag_c%0d", c), 64'(err_flags), 64'({(TO_EN && c >= TO), 5'b0}));
      chk($sformatf("to_pulse_c%0d", c), 64'(err_pulse), 64'(TO_EN && c == TO));
    end
    PREADY = 1'b1; step();
    exp_rd++;
    chk("to_done", 64'(xfer_done), 64'(1));
    chk_counts("to");
    do_clr();

    // Randomized legal traffic against the transfer-level model.
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
      xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end
    do_clr();

    // Counter saturation.
    xfer(1'b0, 32'h40, 32'h0BAD_0BAD, 0, 1'b1);
    for (int k = 0; k < CMAX; k++) xfer(1'b0, 32'h44, $urandom, 0, 1'b0);
    chk("rd_sat", 64'(rd_count), 64'(CMAX));
    chk("slv_once", 64'(slverr_count), 64'(1));

    // clr coinciding with a write completion.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h48; PWDATA = 32'h0000_0048; step();
    PENABLE = 1'b1; PREADY = 1'b1; clr = 1'b1; step();
    clr = 1'b0; idle();
    exp_wr = 1; exp_rd = 0; exp_slv = 0;
    chk_counts("clr_done");
    chk("clr_done_addr", 64'(last_addr), 64'(32'h48));

    // Reset in the middle of ACCESS.
    step();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50; PWDATA = 32'h55; step();
    PENABLE = 1'b1; PREADY = 1'b0; step();
    #2 PRESETn = 1'b0;
    #1;
    exp_wr = 0; exp_rd = 0; exp_slv = 0; exp_flags = '0;
    chk("arst_flags", 64'(err_flags), 64'(0));
    chk("arst_done", 64'(xfer_done), 64'(0));
    chk("arst_laddr", 64'(last_addr), 64'(0));
    chk("arst_ldata", 64'(last_data), 64'(0));
    chk("arst_lwrite", 64'(last_write), 64'(0));
    chk_counts("arst");
    idle(); step();
    PRESETn = 1'b1; step();
    xfer(1'b1, 32'h60, 32'hCAFE_F00D, 1, 1'b0);
    chk("post_rst_wr", 64'(wr_count), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable, parametrised APB protocol monitor that passively observes one APB slave port. It tracks the IDLE/SETUP/ACCESS sequence and flags protocol violations in sticky error bits. It also keeps saturating transfer statistics and captures the last completed transfer. It sits alongside any APB slave (SRAM or peripheral) and gives the same protocol checking in silicon and in gate-level simulation, where SVA is unavailable.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PADDR
- DATA_WIDTH, 32, width of PWDATA/PRDATA (8, 16 or 32)
- COUNT_WIDTH, 16, width of each statistics counter
- TIMEOUT_CYCLES, 16, maximum allowed wait states before a timeout violation (≥1)

Ports:
- PCLK  input  1  APB clock; all state updates on the rising edge
- PRESETn  input  1  asynchronous, active-low reset
- PSEL, PENABLE, PWRITE, PREADY, PSLVERR  input  1 each  observed APB signals
- PADDR  input  ADDR_WIDTH  observed address
- PWDATA, PRDATA  input  DATA_WIDTH  observed data
- clr  input  1  synchronous clear of error flags and counters
- err_flags  output  6  sticky violation bits, [0]..[5] as listed below
- err_pulse  output  1  high one cycle when any violation is detected
- xfer_done  output  1  high one cycle after each completed transfer
- last_addr  output  ADDR_WIDTH  address of the last completed transfer
- last_data  output  DATA_WIDTH  PWDATA on writes, PRDATA on reads
- last_write  output  1  direction of the last completed transfer
- wr_count, rd_count, slverr_count  output  COUNT_WIDTH  completed writes, completed reads, completions with PSLVERR

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. The reset state is IDLE.
- IDLE:
  - PSEL & !PENABLE → SETUP; capture PADDR, PWRITE and PWDATA.
  - PSEL & PENABLE → set [1] ENABLE_NO_SETUP. If the previous cycle completed a transfer, set [3] ENABLE_NOT_DROPPED instead. Stay in IDLE.
  - !PSEL & PENABLE → set [1].
- SETUP:
  - PSEL & PENABLE → ACCESS. If PADDR or PWRITE differs from the captured value, set [2] UNSTABLE. On a write, also set [2] if PWDATA differs.
  - PSEL & !PENABLE → set [0] SETUP_NO_ENABLE; recapture and stay in SETUP.
  - !PSEL → set [0] and go to IDLE.
- ACCESS:
  - !PSEL → set [4] SEL_DROPPED and go to IDLE. No transfer is counted.
  - PSEL & !PENABLE → set [4] and treat the cycle as a new SETUP (recapture).
  - Otherwise run the [2] stability check every cycle against the captured values.
  - PREADY → the transfer completes. Update last_* and increment wr_count or rd_count. Increment slverr_count if PSLVERR is high. Go to IDLE.
- Wait counter:
  - Clears on entry to ACCESS and increments on each ACCESS cycle with PREADY low.
  - When it reaches TIMEOUT_CYCLES, set [5] TIMEOUT once per transfer. Monitoring continues.
- Counters saturate at all-ones and never wrap.
- PSLVERR is ignored when PREADY is low.
- Simultaneous clr and a new violation: the violation bit is set, because set wins. The other bits clear.
- Simultaneous clr and a completion: counters load 1 (or 0 if that counter is not incremented). last_* still update.

## Timing
- Reset values:
  - FSM = IDLE.
  - err_flags = 0, err_pulse = 0, xfer_done = 0.
  - last_addr = 0, last_data = 0, last_write = 0.
  - All counters = 0; wait counter = 0.
- Reset asserted mid-transfer aborts it immediately. Nothing is counted or flagged.
- All outputs are registered.
- A condition sampled at edge N is visible on err_flags/err_pulse from edge N until the next edge.
- xfer_done and the last_*/counter updates appear on the completion edge, with latency 1.
- A zero-wait transfer takes two PCLK edges (SETUP, ACCESS) and produces one xfer_done pulse.
- Back-to-back transfers are legal: ACCESS complete → IDLE with PSEL & !PENABLE enters SETUP in the next cycle, with no idle gap.

## Configuration
- Macro: APB_MON_TIMEOUT_EN.
- Defined: the wait counter and err_flags[5] TIMEOUT are implemented as described above.
- Undefined: no wait counter is built, and err_flags[5] is tied to 0. All other behaviour is identical.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF with 0 waits, then read the same address returning 0xDEAD_BEEF with 2 waits → two xfer_done pulses; wr_count=1, rd_count=1; last_addr=0x10, last_data=0xDEAD_BEEF, last_write=0; err_flags=0.
- PSEL & PENABLE asserted together from IDLE → err_flags=6'b000010, err_pulse=1 for one cycle, no counter change. Then clr → err_flags=0.
- PADDR changes 0x20→0x24 during the second wait state of a write → err_flags[2]=1. The transfer still completes and wr_count increments.
- PREADY held low for 20 cycles with TIMEOUT_CYCLES=16 → err_flags[5] set exactly at the 16th wait cycle and err_pulse asserted once. With APB_MON_TIMEOUT_EN undefined, err_flags stays 0.
- Read completing with PSLVERR=1, then 0xFFFF more read completions with COUNT_WIDTH=16 → slverr_count=1 and rd_count saturates at 0xFFFF.
- PRESETn driven low during ACCESS → all outputs return to reset values asynchronously. A subsequent clean write is counted as wr_count=1.
